// File: rtl/timetag_pkg.sv
// timetag_pkg: shared packetizer state encoding and FX2 packet-size constants
package timetag_pkg;
  typedef enum logic [1:0] {ST_STREAM, ST_PKTEND, ST_HOLDOFF} pkt_state_e;
  localparam int FX2_PKT_LEN_HS = 512;
  localparam int FX2_PKT_LEN_FS = 64;
endpackage

// File: rtl/fx2_packetizer_idle_timer.sv
// idle_timer: saturating idle counter with clear and enable, flags when LIMIT is reached
module idle_timer #(
  parameter int LIMIT = 47999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign hit_o = cnt_q == W'(LIMIT);
  always_comb cnt_d = clr_i ? '0 : (en_i && !hit_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/fx2_packetizer.sv
// fx2_packetizer: byte stream to FX2 slave-FIFO writes, committing short packets on idle or flush
module fx2_packetizer
  import timetag_pkg::*;
#(
  parameter int PKT_LEN       = FX2_PKT_LEN_HS,
  parameter int FLUSH_TIMEOUT = 48000,
  parameter int HOLDOFF       = 4
) (
  input  logic        fx2_clk,
  input  logic        reset,
  input  logic        data_rdy,
  input  logic [7:0]  data,
  output logic        data_ack,
  input  logic        flush_req,
  input  logic        fx2_full,
  output logic        fx2_wr,
  output logic [7:0]  fx2_data,
  output logic        fx2_pktend,
  output logic [15:0] pkt_count
);
  localparam int BW = $clog2(PKT_LEN);
  localparam int HW = $clog2(HOLDOFF + 1);
  pkt_state_e state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [7:0] data_q, data_d;
  logic flush_pending_q, flush_pending_d;
  logic wr_q, wr_d, pktend_q, pktend_d;
  logic accept, wrap, commit, flush_now, timeout_hit;
  assign data_ack   = state_q == ST_STREAM && !fx2_full && !flush_pending_q && !timeout_hit;
  assign accept     = data_rdy && data_ack;
  assign wrap       = accept && byte_cnt_q == BW'(PKT_LEN - 1);
  assign commit     = state_q == ST_PKTEND && !fx2_full;
  assign fx2_wr     = wr_q;
  assign fx2_data   = data_q;
  assign fx2_pktend = pktend_q;
  assign pkt_count  = pkt_count_q;
  // The counter runs one behind the idle cycle count so timeout_hit lands FLUSH_TIMEOUT cycles after the last accept
  idle_timer #(.LIMIT(FLUSH_TIMEOUT - 1)) u_idle (
    .clk   (fx2_clk),
    .rst   (reset),
    .clr_i (accept || commit),
    .en_i  (state_q == ST_STREAM && byte_cnt_q != '0),
    .hit_o (timeout_hit)
  );
  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    byte_cnt_d      = accept ? byte_cnt_q + 1'b1 : byte_cnt_q;
    flush_now       = state_q == ST_STREAM && flush_req && byte_cnt_d != '0;
    flush_pending_d = flush_pending_q || flush_now;
    wr_d            = accept;
    data_d          = accept ? data : data_q;
    pktend_d        = commit;
    pkt_count_d     = pkt_count_q + {15'd0, wrap || commit};
    if (state_q == ST_STREAM && (flush_pending_q || flush_now || timeout_hit) && !wr_q)
      state_d = ST_PKTEND;
    if (commit) begin
      byte_cnt_d      = '0;
      flush_pending_d = 1'b0;
      hold_d          = '0;
      state_d         = ST_HOLDOFF;
    end
    if (state_q == ST_HOLDOFF) begin
      hold_d  = hold_q + 1'b1;
      state_d = hold_q == HW'(HOLDOFF - 1) ? ST_STREAM : ST_HOLDOFF;
    end
  end
  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      state_q         <= ST_STREAM;
      hold_q          <= '0;
      byte_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
      wr_q            <= 1'b0;
      data_q          <= '0;
      pktend_q        <= 1'b0;
      pkt_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      byte_cnt_q      <= byte_cnt_d;
      flush_pending_q <= flush_pending_d;
      wr_q            <= wr_d;
      data_q          <= data_d;
      pktend_q        <= pktend_d;
      pkt_count_q     <= pkt_count_d;
    end
  end
endmodule

// File: tb/tb_fx2_packetizer.sv
// tb_fx2_packetizer: scenario tasks plus a byte-queue reference model of the packet stream
module tb_fx2_packetizer;
  localparam int PKT_LEN = 512;
  localparam int TMO     = 16;
  localparam int HOLD    = 4;
  logic fx2_clk = 0, reset = 1, data_rdy = 0, flush_req = 0, fx2_full = 0;
  logic [7:0] data = 0;
  logic data_ack, fx2_wr, fx2_pktend;
  logic [7:0] fx2_data;
  logic [15:0] pkt_count;
  int checks = 0, errors = 0, cyc = 0;
  int wr_n = 0, pe_n = 0, last_acc = 0, last_pe = 0, wraps = 0, open_bytes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  fx2_packetizer #(.PKT_LEN(PKT_LEN), .FLUSH_TIMEOUT(TMO), .HOLDOFF(HOLD)) dut (
    .fx2_clk(fx2_clk), .reset(reset), .data_rdy(data_rdy), .data(data), .data_ack(data_ack),
    .flush_req(flush_req), .fx2_full(fx2_full), .fx2_wr(fx2_wr), .fx2_data(fx2_data),
    .fx2_pktend(fx2_pktend), .pkt_count(pkt_count)
  );

  always #5 fx2_clk = ~fx2_clk;
  always @(posedge fx2_clk) cyc <= cyc + 1;

  // Reference: every accepted byte must reappear once, in order, on the write port;
  // each commit strobe must close a non-empty partial packet.
  always @(negedge fx2_clk) begin
    if (fx2_wr === 1'b1) begin
      wr_n++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_data: write of %02h with no accepted byte outstanding", fx2_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fx2_data !== mon_exp) begin
          errors++;
          $display("FAIL wr_data: got %02h expected %02h", fx2_data, mon_exp);
        end
      end
    end
    if (fx2_pktend === 1'b1) begin
      pe_n++;
      last_pe = cyc;
      checks++;
      if (fx2_wr !== 1'b0 || open_bytes == 0) begin
        errors++;
        $display("FAIL pktend_ok: wr=%b open_bytes=%0d, expected wr=0 and open_bytes>0", fx2_wr, open_bytes);
      end
      open_bytes = 0;
    end
    if (!reset && data_rdy && data_ack === 1'b1) begin
      exp_q.push_back(data);
      last_acc = cyc;
      open_bytes++;
      if (open_bytes == PKT_LEN) begin
        open_bytes = 0;
        wraps++;
      end
    end
    if (reset) begin
      exp_q.delete();
      open_bytes = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    data_rdy  = 0;
    flush_req = 0;
    repeat (n) begin
      @(posedge fx2_clk);
      #1;
    end
  endtask

  task automatic send(input int n, input int flush_at);
    int sent = 0, guard = 0;
    bit acc;
    data_rdy = 1;
    data = 8'($urandom);
    while (sent < n && guard < n + 200) begin
      flush_req = (sent == flush_at);
      #1;
      acc = data_ack;
      if (acc) sent++;
      @(posedge fx2_clk);
      #1;
      guard++;
      if (acc) data = 8'($urandom);
    end
    data_rdy  = 0;
    flush_req = 0;
    if (sent < n) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sent %0d bytes, required %0d", sent, n);
    end
  endtask

  task automatic wait_pe(input int base, input int limit);
    int n = 0;
    while (pe_n == base && n < limit) begin
      @(posedge fx2_clk);
      #1;
      n++;
    end
  endtask

  task automatic pulse_flush;
    flush_req = 1;
    @(posedge fx2_clk);
    #1;
    flush_req = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge fx2_clk);
    #1;
    reset = 0;
    @(negedge fx2_clk);
    checks += 5;
    if (fx2_wr !== 0) begin errors++; $display("FAIL reset_wr: got %b expected 0", fx2_wr); end
    if (fx2_pktend !== 0) begin errors++; $display("FAIL reset_pktend: got %b expected 0", fx2_pktend); end
    if (fx2_data !== 0) begin errors++; $display("FAIL reset_data: got %02h expected 00", fx2_data); end
    if (pkt_count !== 0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    if (data_ack !== 1) begin errors++; $display("FAIL reset_ack: got %b expected 1", data_ack); end
    @(posedge fx2_clk);
    #1;
  endtask

  task automatic test_full_packet;
    int w0 = wr_n, p0 = pe_n;
    send(PKT_LEN, -1);
    idle(30);
    checks += 4;
    if (wr_n - w0 != PKT_LEN) begin errors++; $display("FAIL full_pkt_writes: got %0d expected %0d", wr_n - w0, PKT_LEN); end
    if (pe_n != p0) begin errors++; $display("FAIL full_pkt_pktend: got %0d strobes expected 0", pe_n - p0); end
    if (pkt_count !== 16'd1) begin errors++; $display("FAIL full_pkt_count: got %0d expected 1", pkt_count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL full_pkt_drain: %0d bytes unwritten expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout;
    int p0 = pe_n;
    send(10, -1);
    wait_pe(p0, 40);
    checks += 4;
    if (pe_n != p0 + 1) begin errors++; $display("FAIL tmo_pktend: got %0d strobes expected 1", pe_n - p0); end
    if (last_pe - last_acc != TMO + 2) begin errors++; $display("FAIL tmo_latency: got %0d cycles expected %0d", last_pe - last_acc, TMO + 2); end
    idle(30);
    if (pe_n != p0 + 1) begin errors++; $display("FAIL tmo_rearm: got %0d strobes expected 1", pe_n - p0); end
    if (pkt_count !== 16'd2) begin errors++; $display("FAIL tmo_count: got %0d expected 2", pkt_count); end
  endtask

  task automatic test_full_stall;
    int p0 = pe_n;
    fx2_full = 1;
    data_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (data_ack !== 0 || fx2_wr !== 0) begin
        errors++;
        $display("FAIL stall_%0d: ack=%b wr=%b expected 0 0", i, data_ack, fx2_wr);
      end
      @(posedge fx2_clk);
      #1;
    end
    fx2_full = 0;
    #1;
    checks++;
    if (data_ack !== 1) begin errors++; $display("FAIL stall_resume: ack=%b expected 1", data_ack); end
    send(30, -1);
    wait_pe(p0, 60);
    idle(10);
    checks += 3;
    if (pe_n != p0 + 1) begin errors++; $display("FAIL stall_pktend: got %0d strobes expected 1", pe_n - p0); end
    if (pkt_count !== 16'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", pkt_count); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d bytes unwritten expected 0", exp_q.size()); end
  endtask

  task automatic test_flush_zero;
    int p0 = pe_n;
    pulse_flush();
    idle(20);
    checks += 2;
    if (pe_n != p0) begin errors++; $display("FAIL flush0_pktend: got %0d strobes expected 0", pe_n - p0); end
    if (pkt_count !== 16'd3) begin errors++; $display("FAIL flush0_count: got %0d expected 3", pkt_count); end
  endtask

  task automatic test_flush_wrap;
    int p0 = pe_n;
    send(PKT_LEN, PKT_LEN - 1);
    idle(30);
    checks += 2;
    if (pe_n != p0) begin errors++; $display("FAIL flushwrap_pktend: got %0d strobes expected 0", pe_n - p0); end
    if (pkt_count !== 16'd4) begin errors++; $display("FAIL flushwrap_count: got %0d expected 4", pkt_count); end
  endtask

  task automatic test_flush_latency;
    int p0 = pe_n, m;
    send(5, -1);
    idle(3);
    m = cyc;
    pulse_flush();
    wait_pe(p0, 20);
    checks += 2;
    if (last_pe - m != 2 || pe_n != p0 + 1) begin
      errors++;
      $display("FAIL flush_latency: got %0d cycles (%0d strobes) expected 2 (1)", last_pe - m, pe_n - p0);
    end
    idle(10);
    if (pkt_count !== 16'd5) begin errors++; $display("FAIL flush_count: got %0d expected 5", pkt_count); end
  endtask

  task automatic test_flush_full;
    int p0 = pe_n, n = 0;
    send(3, -1);
    fx2_full = 1;
    idle(2);
    pulse_flush();
    idle(10);
    checks++;
    if (pe_n != p0) begin errors++; $display("FAIL flushfull_hold: got %0d strobes expected 0", pe_n - p0); end
    fx2_full = 0;
    while (fx2_pktend !== 1'b1 && n < 10) begin
      @(negedge fx2_clk);
      n++;
    end
    for (int i = 0; i < HOLD; i++) begin
      checks++;
      if (data_ack !== 0) begin errors++; $display("FAIL holdoff_%0d: ack=%b expected 0", i, data_ack); end
      @(negedge fx2_clk);
    end
    checks++;
    if (data_ack !== 1) begin errors++; $display("FAIL holdoff_end: ack=%b expected 1", data_ack); end
    @(posedge fx2_clk);
    #1;
    idle(10);
    checks += 2;
    if (pe_n != p0 + 1) begin errors++; $display("FAIL flushfull_pktend: got %0d strobes expected 1", pe_n - p0); end
    if (pkt_count !== 16'd6) begin errors++; $display("FAIL flushfull_count: got %0d expected 6", pkt_count); end
  endtask

  task automatic test_reset_mid;
    int p0;
    send(200, -1);
    reset = 1;
    @(posedge fx2_clk);
    #1;
    reset = 0;
    @(negedge fx2_clk);
    checks += 3;
    if (fx2_wr !== 0) begin errors++; $display("FAIL midrst_wr: got %b expected 0", fx2_wr); end
    if (fx2_pktend !== 0) begin errors++; $display("FAIL midrst_pktend: got %b expected 0", fx2_pktend); end
    if (pkt_count !== 0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", pkt_count); end
    @(posedge fx2_clk);
    #1;
    p0 = pe_n;
    idle(TMO + 20);
    checks++;
    if (pe_n != p0) begin errors++; $display("FAIL midrst_abandon: got %0d strobes expected 0", pe_n - p0); end
  endtask

  task automatic test_random;
    int w0 = wraps, p0 = pe_n;
    for (int i = 0; i < 1500; i++) begin
      data_rdy  = $urandom_range(0, 9) < 7;
      data      = 8'($urandom);
      fx2_full  = $urandom_range(0, 9) == 0;
      flush_req = $urandom_range(0, 39) == 0;
      @(posedge fx2_clk);
      #1;
    end
    fx2_full = 0;
    idle(80);
    checks += 3;
    if (pkt_count !== 16'(wraps - w0 + pe_n - p0)) begin
      errors++;
      $display("FAIL rand_count: got %0d expected %0d", pkt_count, wraps - w0 + pe_n - p0);
    end
    if (open_bytes != 0) begin errors++; $display("FAIL rand_commit: %0d bytes uncommitted expected 0", open_bytes); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: %0d bytes unwritten expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_timeout();
    test_full_stall();
    test_flush_zero();
    test_flush_wrap();
    test_flush_latency();
    test_flush_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
